// File: rtl/pyjamask96_stream_master.sv
// pyjamask96_stream_master
//
// Streams one 96-bit block plus a 128-bit key into a byte-serial Pyjamask-96
// core, fires the core, then gathers its 12 result bytes into a 96-bit word
// that is held until the host takes it.
//
// Ports
//   clk, reset_n               rising-edge clock, async active-low reset
//   blk_valid/blk_ready        block handshake (ready only in IDLE)
//   blk_text[95:0]             plaintext, byte i = bits [8i+7:8i]
//   blk_key[127:0]             key, byte i = bits [8i+7:8i]
//   load, start                core control strobes
//   byte_in, byte_key_in       core byte inputs (0 outside SEND)
//   core_valid, core_byte_out  core result byte stream
//   res_valid/res_ready        result handshake (valid only in HOLD)
//   res_text[95:0]             ciphertext, byte i = bits [8i+7:8i]
//   busy                       high in every state except IDLE
//   err                        one-cycle timeout pulse
//
// Configuration
//   PYJ96_STREAM_TIMEOUT_EN    when defined, a 10-bit watchdog aborts WAIT/COLLECT
//                              after 1023 cycles and pulses err; otherwise err = 0
//                              and the block waits for the core indefinitely.

module pyjamask96_stream_master (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [95:0]  blk_text,
    input  logic [127:0] blk_key,
    output logic         load,
    output logic         start,
    output logic [7:0]   byte_in,
    output logic [7:0]   byte_key_in,
    input  logic         core_valid,
    input  logic [7:0]   core_byte_out,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [95:0]  res_text,
    output logic         busy,
    output logic         err
);

    typedef enum logic [2:0] {IDLE, SEND, KICK, WAIT, COLLECT, HOLD} state_t;

    state_t       state, state_nxt;
    logic [3:0]   k;          // SEND byte index
    logic [3:0]   j;          // next result byte index
    logic [95:0]  text_r;
    logic [127:0] key_r;
    logic [95:0]  res_r;
    logic         cap;        // capture a result byte this cycle
    logic         timeout;
    logic [127:0] text_ext;

`ifdef PYJ96_STREAM_TIMEOUT_EN
    logic [9:0]   tmo_cnt;
`endif

    // Text padded to 16 bytes so SEND bytes 12..15 read as zero.
    assign text_ext = {32'h0, text_r};

    always_comb begin
        state_nxt = state;
        timeout   = 1'b0;
`ifdef PYJ96_STREAM_TIMEOUT_EN
        if ((state == WAIT || state == COLLECT) && tmo_cnt == 10'd1023)
            timeout = 1'b1;
`endif
        cap = (state == WAIT || state == COLLECT) && core_valid && !timeout;

        case (state)
            IDLE:    if (blk_valid)             state_nxt = SEND;
            SEND:    if (k == 4'd15)            state_nxt = KICK;
            KICK:                               state_nxt = WAIT;
            WAIT:    if (cap)                   state_nxt = COLLECT;
            COLLECT: if (cap && j == 4'd11)     state_nxt = HOLD;
            HOLD:    if (res_ready)             state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase

        // The watchdog wins over any byte arriving on the same cycle.
        if (timeout)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            k      <= 4'd0;
            j      <= 4'd0;
            text_r <= '0;
            key_r  <= '0;
            res_r  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && blk_valid) begin
                text_r <= blk_text;
                key_r  <= blk_key;
            end
            k <= (state == SEND) ? k + 4'd1 : 4'd0;
            if (state == KICK)
                j <= 4'd0;
            else if (cap) begin
                res_r[{j, 3'b000} +: 8] <= core_byte_out;
                j <= j + 4'd1;
            end
        end
    end

`ifdef PYJ96_STREAM_TIMEOUT_EN
    // Cleared while in KICK so it reads 0 on the first WAIT cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            tmo_cnt <= 10'd0;
        else if (state == KICK)
            tmo_cnt <= 10'd0;
        else if (state == WAIT || state == COLLECT)
            tmo_cnt <= tmo_cnt + 10'd1;
    end
    assign err = timeout;
`else
    assign err = 1'b0;
`endif

    assign blk_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign load        = (state == SEND);
    assign start       = (state == KICK);
    assign res_valid   = (state == HOLD);
    assign res_text    = res_r;
    assign byte_key_in = load ? key_r[{k, 3'b000} +: 8]    : 8'h00;
    assign byte_in     = load ? text_ext[{k, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_pyjamask96_stream_master.sv
// Self-checking bench for pyjamask96_stream_master: a table of block/core
// response records (two fixed, the rest random) is streamed through the
// block while a reference of the expected byte streams is derived from the
// record contents; hand-written sequences cover reset mid-SEND and the
// WAIT timeout / indefinite wait.

module tb_pyjamask96_stream_master;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         blk_valid;
    logic         blk_ready;
    logic [95:0]  blk_text;
    logic [127:0] blk_key;
    logic         load;
    logic         start;
    logic [7:0]   byte_in;
    logic [7:0]   byte_key_in;
    logic         core_valid;
    logic [7:0]   core_byte_out;
    logic         res_valid;
    logic         res_ready;
    logic [95:0]  res_text;
    logic         busy;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pyjamask96_stream_master dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .blk_text     (blk_text),
        .blk_key      (blk_key),
        .load         (load),
        .start        (start),
        .byte_in      (byte_in),
        .byte_key_in  (byte_key_in),
        .core_valid   (core_valid),
        .core_byte_out(core_byte_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_text     (res_text),
        .busy         (busy),
        .err          (err)
    );

    typedef struct {
        logic [95:0]  text;
        logic [127:0] key;
        logic [95:0]  core_bytes;   // byte b delivered b-th by the core model
        int           latency;      // idle WAIT cycles before byte 0
        int           stall_after;  // stall inserted after this byte index
        int           stall_len;
        int           hold;         // cycles res_ready held low
        logic [95:0]  exp_res;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_text_byte(input logic [95:0] t, input int idx);
        if (idx < 12) return t[8*idx +: 8];
        return 8'h00;
    endfunction

    function automatic logic [95:0] rnd96();
        return {$urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic accept_block(input logic [95:0] t, input logic [127:0] kk);
        int waited = 0;
        while (!blk_ready && waited < 50) begin
            tick();
            waited++;
        end
        chk("blk_ready_before_accept", blk_ready, 1'b1);
        blk_valid = 1'b1;
        blk_text  = t;
        blk_key   = kk;
        tick();
        blk_valid = 1'b0;
        blk_text  = rnd96();    // captured copy must be used, not the live bus
        blk_key   = rnd128();
    endtask

    // Drives SEND and KICK, checking the byte stream; leaves the DUT in WAIT cycle 0.
    task automatic send_and_kick(input logic [95:0] t, input logic [127:0] kk);
        for (int i = 0; i < 16; i++) begin
            chk("send_load", load, 1'b1);
            chk("send_byte_key_in", byte_key_in, kk[8*i +: 8]);
            chk("send_byte_in", byte_in, exp_text_byte(t, i));
            chk("send_start", start, 1'b0);
            chk("send_blk_ready", blk_ready, 1'b0);
            core_valid    = 1'($urandom_range(0, 1));  // ignored outside WAIT/COLLECT
            core_byte_out = 8'($urandom);
            tick();
        end
        chk("kick_start", start, 1'b1);
        chk("kick_load", load, 1'b0);
        chk("kick_byte_in", byte_in, 8'h00);
        chk("kick_byte_key_in", byte_key_in, 8'h00);
        core_valid    = 1'($urandom_range(0, 1));
        core_byte_out = 8'($urandom);
        tick();
        core_valid = 1'b0;
    endtask

    task automatic deliver_and_take(input vec_t v);
        for (int b = 0; b < 12; b++) begin
            if (b == v.stall_after + 1) begin
                for (int s = 0; s < v.stall_len; s++) begin
                    core_valid    = 1'b0;
                    core_byte_out = 8'($urandom);
                    chk("stall_res_valid", res_valid, 1'b0);
                    chk("stall_busy", busy, 1'b1);
                    tick();
                end
            end
            chk("collect_res_valid", res_valid, 1'b0);
            core_valid    = 1'b1;
            core_byte_out = v.core_bytes[8*b +: 8];
            tick();
        end
        core_valid    = 1'b1;           // core chatter in HOLD must be ignored
        core_byte_out = 8'($urandom);
        chk("res_valid_after_byte11", res_valid, 1'b1);
        chk("res_text", res_text, v.exp_res);
        chk("hold_blk_ready", blk_ready, 1'b0);
        for (int h = 0; h < v.hold; h++) begin
            res_ready     = 1'b0;
            blk_valid     = 1'b1;
            blk_text      = rnd96();
            core_byte_out = 8'($urandom);
            tick();
            chk("hold_res_valid", res_valid, 1'b1);
            chk("hold_res_text", res_text, v.exp_res);
            chk("hold_blk_not_accepted", blk_ready, 1'b0);
        end
        blk_valid  = 1'b0;
        core_valid = 1'b0;
        res_ready  = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("release_res_valid", res_valid, 1'b0);
        chk("release_blk_ready", blk_ready, 1'b1);
        chk("release_busy", busy, 1'b0);
    endtask

    task automatic run_txn(input vec_t v);
        accept_block(v.text, v.key);
        send_and_kick(v.text, v.key);
        for (int l = 0; l < v.latency; l++) begin
            core_valid    = 1'b0;
            core_byte_out = 8'($urandom);
            chk("wait_start", start, 1'b0);
            chk("wait_res_valid", res_valid, 1'b0);
            chk("wait_err", err, 1'b0);
            tick();
        end
        chk("wait_busy", busy, 1'b1);
        deliver_and_take(v);
    endtask

    initial begin
        vec_t v;

        reset_n       = 1'b0;
        blk_valid     = 1'b0;
        blk_text      = '0;
        blk_key       = '0;
        core_valid    = 1'b0;
        core_byte_out = 8'h00;
        res_ready     = 1'b0;

        // Vector table: two directed records, then random ones.
        vecs[0].text        = 96'h0B0A09080706050403020100;
        vecs[0].key         = 128'h0F0E0D0C0B0A09080706050403020100;
        vecs[0].core_bytes  = 96'hABAAA9A8A7A6A5A4A3A2A1A0;
        vecs[0].latency     = 3;
        vecs[0].stall_after = 99;
        vecs[0].stall_len   = 0;
        vecs[0].hold        = 0;
        vecs[0].exp_res     = 96'hABAAA9A8A7A6A5A4A3A2A1A0;
        vecs[1]             = vecs[0];
        vecs[1].stall_after = 5;
        vecs[1].stall_len   = 3;
        vecs[1].hold        = 5;
        for (int i = 2; i < 8; i++) begin
            vecs[i].text        = rnd96();
            vecs[i].key         = rnd128();
            vecs[i].core_bytes  = rnd96();
            vecs[i].latency     = int'($urandom_range(0, 20));
            vecs[i].stall_after = int'($urandom_range(0, 10));
            vecs[i].stall_len   = int'($urandom_range(0, 4));
            vecs[i].hold        = int'($urandom_range(0, 6));
            vecs[i].exp_res     = vecs[i].core_bytes;  // result = bytes in arrival order
        end
`ifndef PYJ96_STREAM_TIMEOUT_EN
        vecs[7].latency = 1100;  // no watchdog: a long core latency must just wait
`endif

        tick();
        tick();
        chk("reset_blk_ready_in_reset", blk_ready, 1'b1);
        chk("reset_busy_in_reset", busy, 1'b0);
        reset_n = 1'b1;
        tick();
        chk("idle_blk_ready", blk_ready, 1'b1);
        chk("idle_busy", busy, 1'b0);
        chk("idle_load", load, 1'b0);
        chk("idle_start", start, 1'b0);
        chk("idle_res_valid", res_valid, 1'b0);
        chk("idle_err", err, 1'b0);
        chk("idle_res_text", res_text, 96'h0);
        chk("idle_byte_in", byte_in, 8'h00);
        chk("idle_byte_key_in", byte_key_in, 8'h00);

        // res_ready with no result pending is ignored.
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("stray_res_ready_res_valid", res_valid, 1'b0);
        chk("stray_res_ready_blk_ready", blk_ready, 1'b1);

        for (int i = 0; i < 8; i++)
            run_txn(vecs[i]);

        // Reset asserted at SEND k=7: outputs drop at once, nothing follows release.
        v = vecs[2];
        accept_block(v.text, v.key);
        for (int i = 0; i < 7; i++) tick();
        chk("k7_load", load, 1'b1);
        chk("k7_byte_key_in", byte_key_in, v.key[63:56]);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_load", load, 1'b0);
        chk("async_rst_byte_key_in", byte_key_in, 8'h00);
        chk("async_rst_byte_in", byte_in, 8'h00);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_blk_ready", blk_ready, 1'b1);
        chk("async_rst_res_text", res_text, 96'h0);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("post_rst_start", start, 1'b0);
            chk("post_rst_res_valid", res_valid, 1'b0);
            chk("post_rst_err", err, 1'b0);
            chk("post_rst_busy", busy, 1'b0);
        end

`ifdef PYJ96_STREAM_TIMEOUT_EN
        // Core never answers: err one cycle, 1023 cycles after WAIT entry, then IDLE.
        v = vecs[3];
        accept_block(v.text, v.key);
        send_and_kick(v.text, v.key);
        for (int n = 0; n < 1023; n++) begin
            chk("tmo_err_early", err, 1'b0);
            tick();
        end
        chk("tmo_err_pulse", err, 1'b1);
        chk("tmo_busy_at_pulse", busy, 1'b1);
        chk("tmo_res_valid_at_pulse", res_valid, 1'b0);
        tick();
        chk("tmo_err_cleared", err, 1'b0);
        chk("tmo_blk_ready", blk_ready, 1'b1);
        chk("tmo_res_valid", res_valid, 1'b0);
        // Block must be fully usable after an abort.
        run_txn(vecs[4]);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pyjamask96_stream_master.md
PYJAMASK96_STREAM_MASTER -- requirements
Module: pyjamask96_stream_master

Interface
REQ-001 The block SHALL have a single clock `clk` and an asynchronous, active-low reset `reset_n`.
REQ-002 Ports SHALL be as follows (clock and reset first):
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `blk_valid`  in  1  host offers one block.
- `blk_ready`  out  1  block accepted when `blk_valid` & `blk_ready`.
- `blk_text`  in  96  plaintext; byte i = bits [8i+7:8i].
- `blk_key`  in  128  key; byte i = bits [8i+7:8i].
- `load`  out  1  drives the core's `load`.
- `start`  out  1  drives the core's `start`.
- `byte_in`  out  8  drives the core's `byte_in`.
- `byte_key_in`  out  8  drives the core's `byte_key_in`.
- `core_valid`  in  1  from the core's `valid`.
- `core_byte_out`  in  8  from the core's `byte_out`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  host takes the result.
- `res_text`  out  96  ciphertext; byte i = bits [8i+7:8i].
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  one-cycle timeout pulse.

Function
REQ-003 The FSM SHALL have exactly the states IDLE, SEND, KICK, WAIT, COLLECT and HOLD.
REQ-004 `blk_ready` SHALL be 1 only in IDLE (registered-state decode).
REQ-005 On handshake in IDLE, the block SHALL capture `blk_text`/`blk_key` into internal registers and enter SEND next cycle.
REQ-006 SEND SHALL last exactly 16 cycles, with a 4-bit index k=0..15 and `load`=1 each cycle.
- `byte_key_in` = key byte k.
- `byte_in` = text byte k for k<=11, else 8'h00.
REQ-007 After k=15, KICK SHALL last one cycle with `start`=1, `load`=0 and byte outputs at 8'h00, then go to WAIT.
REQ-008 Outside SEND, `load`, `byte_in` and `byte_key_in` SHALL be 0; outside KICK, `start` SHALL be 0.
REQ-009 In WAIT, the first cycle with `core_valid`=1 SHALL capture `core_byte_out` as result byte 0 and enter COLLECT.
REQ-010 In COLLECT, each cycle with `core_valid`=1 SHALL capture the next byte (index j, 0..11, LSB first).
- Cycles with `core_valid`=0 SHALL stall j without capture and without error.
REQ-011 Capture of byte 11 SHALL move the FSM to HOLD with `res_valid`=1 on the next cycle.
- `res_text` SHALL stay stable while `res_valid`=1.
REQ-012 `res_valid` & `res_ready` SHALL return the FSM to IDLE next cycle; `blk_ready`=1 in that cycle.
- `res_ready` while `res_valid`=0 SHALL be ignored.
REQ-013 `core_valid` during IDLE, SEND, KICK or HOLD SHALL be ignored.
REQ-014 Latency SHALL be: 16 SEND + 1 KICK cycles, then core latency, then at least 12 collect cycles, then `res_valid`.
REQ-015 `blk_valid` while `busy`=1 SHALL not be accepted; the host holds it.

Reset
REQ-016 `reset_n`=0 SHALL asynchronously force IDLE, zero all counters, data registers and `res_text`, and drive all outputs to 0 except `blk_ready`.
- `blk_ready` SHALL be 1 after reset release.
REQ-017 Reset mid-transfer SHALL discard partial work; no `res_valid` or `err` pulse SHALL follow release.

Configuration
REQ-018 Macro `PYJ96_STREAM_TIMEOUT_EN` defined: a 10-bit cycle counter SHALL clear on entry to WAIT and increment every cycle in WAIT or COLLECT.
- On reaching 1023 before byte 11 is captured, `err` SHALL pulse for one cycle, the FSM SHALL go to IDLE and `res_valid` SHALL stay 0.
REQ-019 Macro undefined: the counter SHALL be absent, `err` SHALL be tied to 0, and WAIT/COLLECT SHALL wait indefinitely.

Verification
REQ-020 Reset then idle: `blk_ready`=1; `busy`, `load`, `start`, `res_valid` and `err` are 0; `res_text`=0.
REQ-021 Text 96'h0B0A09080706050403020100, key 128'h0F0E...0100 -> `load`=1 for 16 cycles.
- `byte_key_in` = 00..0F.
- `byte_in` = 00..0B, then 00 x4.
- `start` = 1 exactly one cycle later.
REQ-022 Core model returns 12 bytes A0..AB back-to-back -> `res_text`=96'hABAAA9A8A7A6A5A4A3A2A1A0 with `res_valid`=1 the cycle after AB.
REQ-023 Same result with `core_valid` low for 3 cycles after byte 5 -> identical `res_text`; collection stretches by 3 cycles.
REQ-024 `res_ready` held 0 for 5 cycles -> `res_valid` and `res_text` stable.
- A new `blk_valid` is not accepted until the cycle after `res_ready`=1.
REQ-025 `reset_n` pulsed at SEND k=7 -> all outputs return to reset values immediately; no `start` is issued.
- With `PYJ96_STREAM_TIMEOUT_EN` and `core_valid` never asserted: `err` pulses once, 1023 cycles after WAIT entry, then IDLE.
